// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, FSM state encodings and sizing helpers for the instruction-memory responder
package imem_pkg;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  function automatic int cnt_width(input int lat);
    return lat <= 2 ? 1 : $clog2(lat);
  endfunction
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response handshake, flush and image-write bus
// master = fetch side (drives req_*, resp_ready, flush, wr_*); slave = memory responder
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  modport master (
    output req_valid, req_addr, resp_ready, flush, wr_en, wr_addr, wr_data, wr_strb,
    input  req_ready, resp_valid, resp_inst, resp_err
  );
  modport slave (
    input  req_valid, req_addr, resp_ready, flush, wr_en, wr_addr, wr_data, wr_strb,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction storage, registered read (old data on same-edge write), byte-strobe write
// ports: clk; rd_en/rd_idx -> rd_data (next edge); wr_en/wr_idx/wr_data/wr_strb
module imem_array #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction fetch responder with fixed latency, fault checks and write port
// ports: clk; rst (async, active-low); bus (slave modport: req/resp handshake, flush, image write)
module imem_responder import imem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int DEPTH = 4096,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  imem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(LATENCY);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + 33'(4 * DEPTH);
  // 33-bit compare so windows ending at the top of the address space do not wrap
  function automatic logic addr_ok(input logic [31:0] a);
    return {1'b0, a} >= LO && {1'b0, a} < HI && a[1:0] == 2'b00;
  endfunction
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hit, err, accept, req_ok;
  logic [31:0]   rd_data;
  assign req_ok = addr_ok(bus.req_addr);
  assign accept = bus.req_valid && bus.req_ready && !bus.flush;
  assign bus.req_ready = rst && state == S_IDLE;
  assign bus.resp_valid = state == S_RESP;
  assign bus.resp_err = err;
  assign bus.resp_inst = hit ? rd_data : NOP_INST;
  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk),
    .rd_en(accept && req_ok),
    .rd_idx(AW'((bus.req_addr - BASE_ADDR) >> 2)),
    .rd_data(rd_data),
    .wr_en(bus.wr_en && addr_ok(bus.wr_addr)),
    .wr_idx(AW'((bus.wr_addr - BASE_ADDR) >> 2)),
    .wr_data(bus.wr_data),
    .wr_strb(bus.wr_strb)
  );
  always_comb begin
    state_n = bus.flush && state != S_IDLE ? S_IDLE :
              state == S_IDLE ? (accept ? (LATENCY > 1 ? S_WAIT : S_RESP) : S_IDLE) :
              state == S_WAIT ? (cnt == CW'(1) ? S_RESP : S_WAIT) :
              state == S_RESP && !bus.resp_ready ? S_RESP : S_IDLE;
    cnt_n = accept ? CW'(LATENCY - 1) : state == S_WAIT && cnt != '0 ? cnt - CW'(1) : cnt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hit   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        hit <= req_ok;
        err <= !req_ok;
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed stimulus with a response scoreboard for imem_responder
module tb_imem_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] inst; logic err;} exp_t;
  logic clk, rst;
  imem_responder_if bus();
  imem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(4096), .LATENCY(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  exp_t q[$];
  int vectors = 0;
  int errs = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_strb = s;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic wait_resp(input string name);
    int n;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 1);
    tick();
  endtask
  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] inst, input logic err);
    q.push_back('{inst, err});
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    tick();
    bus.req_valid = 1'b0;
    wait_resp(name);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready && !bus.flush) begin
        if (q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL unexpected_resp: got inst %h err %b expected no response", bus.resp_inst, bus.resp_err);
        end else begin
          e = q.pop_front();
          chk("resp_inst", bus.resp_inst, e.inst);
          chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.resp_ready = 1'b0;
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_strb = '0;
    #3 rst = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_inst", bus.resp_inst, NOP);
    chk("rst_resp_err", 32'(bus.resp_err), 0);
    rst = 1'b1;
    tick();
    chk("idle_req_ready", 32'(bus.req_ready), 1);
    wr(32'h8000_0000, 32'h0010_0093, 4'hF);
    wr(32'h8000_0004, 32'h1111_1111, 4'hF);
    wr(32'h8000_0008, 32'h0020_0113, 4'hF);
    wr(32'h8000_3FFC, 32'h1234_5678, 4'hF);
    // scenario 1: latency and req_ready timing
    q.push_back('{32'h0010_0093, 1'b0});
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0000;
    tick();
    bus.req_valid = 1'b0;
    chk("t1_req_ready", 32'(bus.req_ready), 0);
    chk("t1_resp_valid", 32'(bus.resp_valid), 0);
    tick();
    chk("t2_resp_valid", 32'(bus.resp_valid), 1);
    chk("t2_req_ready", 32'(bus.req_ready), 0);
    // scenario 2: response held stable under backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(bus.resp_valid), 1);
      chk("hold_inst", bus.resp_inst, 32'h0010_0093);
      chk("hold_err", 32'(bus.resp_err), 0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("after_hs_req_ready", 32'(bus.req_ready), 1);
    chk("after_hs_resp_valid", 32'(bus.resp_valid), 0);
    // scenario 3: range and alignment faults
    fetch("oor_top", 32'h8000_4000, NOP, 1'b1);
    fetch("misalign", 32'h8000_0002, NOP, 1'b1);
    fetch("no_wrap", 32'hFFFF_FFFC, NOP, 1'b1);
    fetch("below_base", 32'h7FFF_FFFC, NOP, 1'b1);
    fetch("last_word", 32'h8000_3FFC, 32'h1234_5678, 1'b0);
    // ignored writes: out of range must not alias onto word 0, misaligned dropped
    wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF);
    wr(32'h8000_0002, 32'hFFFF_FFFF, 4'hF);
    fetch("ignored_wr", 32'h8000_0000, 32'h0010_0093, 1'b0);
    // scenario 4: flush in WAIT
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0000;
    tick();
    bus.req_valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_wait_valid", 32'(bus.resp_valid), 0);
    chk("flush_wait_ready", 32'(bus.req_ready), 1);
    fetch("after_flush", 32'h8000_0008, 32'h0020_0113, 1'b0);
    // flush in IDLE blocks acceptance
    bus.req_valid = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush_idle_ready", 32'(bus.req_ready), 1);
    tick();
    tick();
    chk("flush_idle_valid", 32'(bus.resp_valid), 0);
    // flush in RESP discards the response
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("flush_resp_pre", 32'(bus.resp_valid), 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_resp_valid", 32'(bus.resp_valid), 0);
    chk("flush_resp_ready", 32'(bus.req_ready), 1);
    bus.resp_ready = 1'b1;
    // scenario 5: same-edge write returns old word
    q.push_back('{32'h1111_1111, 1'b0});
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0004;
    bus.wr_en = 1'b1;
    bus.wr_addr = 32'h8000_0004;
    bus.wr_data = 32'hDEAD_BEEF;
    bus.wr_strb = 4'hF;
    tick();
    bus.req_valid = 1'b0;
    bus.wr_en = 1'b0;
    wait_resp("coh_old");
    fetch("coh_new", 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    wr(32'h8000_0004, 32'h0000_00AA, 4'b0001);
    fetch("strb", 32'h8000_0004, 32'hDEAD_BEAA, 1'b0);
    // write during WAIT does not alter the pending response
    q.push_back('{32'h0020_0113, 1'b0});
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0008;
    tick();
    bus.req_valid = 1'b0;
    wr(32'h8000_0008, 32'h0, 4'hF);
    chk("late_wr_valid", 32'(bus.resp_valid), 1);
    tick();
    // scenario 6: asynchronous reset during WAIT
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0000;
    tick();
    bus.req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.resp_valid), 0);
    chk("async_rst_ready", 32'(bus.req_ready), 0);
    chk("async_rst_inst", bus.resp_inst, NOP);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.resp_valid), 0);
    fetch("post_rst", 32'h8000_0000, 32'h0010_0093, 1'b0);
    tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch side of the core over a valid/ready request/response handshake.
- One outstanding fetch at a time, with programmable response latency.
- Performs address range and alignment checks and holds the instruction words.
- A word-write port preloads or patches the image. It replaces the zero-latency DPI fetch path so the fetch unit can be exercised against realistic memory timing.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words; power of two.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  core clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request
- req_addr  input  32  fetch byte address (the pc)
- resp_valid  output  1  response present
- resp_ready  input  1  fetch unit accepts response
- resp_inst  output  32  fetched instruction
- resp_err  output  1  access fault (out of range or misaligned)
- flush  input  1  cancel outstanding fetch (redirect: branch/ecall/mret)
- wr_en  input  1  image write strobe
- wr_addr  input  32  write byte address, word aligned
- wr_data  input  32  write data
- wr_strb  input  4  byte enables for the write

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=0 while rst is low, resp_valid=0, resp_inst=32'h00000013 (NOP), resp_err=0, latency counter=0.
  - Array contents are not reset.
  - Reset mid-transaction drops the request silently.
- States:
  - IDLE: req_ready=1, resp_valid=0. req_valid&&req_ready with flush=0 -> capture address checks, read the array word (read-before-write), load cnt=LATENCY-1. Next state is WAIT if LATENCY>1, else RESP.
  - WAIT: req_ready=0. cnt decrements each cycle; cnt==1 -> RESP next cycle. resp_valid asserts exactly LATENCY cycles after the accept edge.
  - RESP: resp_valid=1; resp_inst/resp_err stable until resp_ready. resp_valid&&resp_ready -> IDLE; the next request is accepted no earlier than the following cycle (no same-cycle turnaround).
- Fault check at accept:
  - In range when BASE_ADDR <= addr < BASE_ADDR+4*DEPTH, computed with 33-bit arithmetic so the top of address space does not wrap.
  - Misaligned when addr[1:0]!=0.
  - Either fault -> resp_err=1, resp_inst=NOP, no array read.
- Word index = (addr-BASE_ADDR)>>2, truncated to $clog2(DEPTH) bits after the range check.
- Data coherence:
  - Read data is captured at the accept edge. Writes after acceptance do not alter the pending response.
  - A write on the accept edge to the same word returns the old word.
- Writes:
  - wr_en performs a byte-masked write on any cycle in any state.
  - Out-of-range or misaligned writes are ignored; no error port.
- flush:
  - IDLE: the request presented the same cycle is not accepted.
  - WAIT: abort -> IDLE next cycle, no response.
  - RESP: resp_valid drops next cycle, response discarded, return to IDLE.
  - flush overrides resp_ready.
- resp_ready held high with no response pending has no effect. req_valid deasserting while not ready is legal; the fetch side is not required to hold.

Decomposition:
- Package imem_pkg: BASE_ADDR default, NOP_INST=32'h00000013, state enum (IDLE, WAIT, RESP), latency counter width function.
- Sub-module imem_array: DEPTH x 32 storage, synchronous read with read-before-write, byte-strobe write. Instantiated once; FSM, counter and fault logic stay in imem_responder.

Test Plan:
1. Preload word 0 = 32'h00100093 via wr_en. Request addr 32'h80000000 at cycle T with LATENCY=2 -> resp_valid at T+2, resp_inst=32'h00100093, resp_err=0; req_ready=0 on T+1..T+2.
2. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_inst and resp_err unchanged throughout. Raise resp_ready -> IDLE and req_ready=1 the next cycle.
3. Out-of-range and misaligned checks:
   - Request 32'h80004000 (DEPTH=4096) -> resp_err=1, resp_inst=32'h00000013.
   - Request 32'h80000002 -> resp_err=1.
   - Request 32'hFFFFFFFC -> resp_err=1 (no wrap).
4. flush in WAIT one cycle after accept -> no resp_valid ever for that request; a new request next cycle returns correct data.
5. Coherence: write word 1 = 32'hDEADBEEF on the same edge a request to 32'h80000004 is accepted -> the old value is returned. A following request returns 32'hDEADBEEF. Strobe 4'b0001 write of 32'h000000AA changes only byte 0.
6. Assert rst low during WAIT -> resp_valid=0 and state IDLE immediately (asynchronous). After release, the first request behaves as in scenario 1.
